// File: rtl/kernel3_gmem_a_m_axi_reg_pipe_pkg.sv
// Shared constants for the gmem_A AXI channel register pipeline.
// Full-mode state encodings keep bit 0 equal to m_valid.
package kernel3_gmem_A_m_axi_pkg;

  localparam int MODE_BYPASS = 0;
  localparam int MODE_FWD    = 1;
  localparam int MODE_REV    = 2;
  localparam int MODE_FULL   = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b10,
    ST_ONE   = 2'b11,
    ST_TWO   = 2'b01
  } full_state_e;

  function automatic bit mode_ok(input int m);
    return (m >= MODE_BYPASS) && (m <= MODE_FULL);
  endfunction

endpackage

// File: rtl/kernel3_gmem_a_m_axi_reg_pipe_stage.sv
// One valid/ready slice; MODE picks full skid, forward, reverse or bypass.
// Data registers are intentionally left out of reset.
module kernel3_gmem_A_m_axi_reg_stage
  import kernel3_gmem_A_m_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = MODE_FULL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  occupied
);

  if (MODE == MODE_FULL) begin : g_full
    full_state_e           state, state_nxt;
    logic [DATA_WIDTH-1:0] p1, p2;
    logic                  rdy_r, rdy_nxt;
    logic                  s_xfer, ld_p1_s, ld_p1_p2, ld_p2;

    assign s_xfer = s_valid && rdy_r;

    always_comb begin
      state_nxt = state;
      rdy_nxt   = rdy_r;
      ld_p1_s   = 1'b0;
      ld_p1_p2  = 1'b0;
      ld_p2     = 1'b0;
      case (state)
        ST_EMPTY: begin
          rdy_nxt = 1'b1;
          if (s_xfer) begin
            state_nxt = ST_ONE;
            ld_p1_s   = 1'b1;
          end
        end
        ST_ONE: begin
          if (s_xfer && m_ready) begin
            ld_p1_s = 1'b1;
          end else if (s_xfer) begin
            state_nxt = ST_TWO;
            rdy_nxt   = 1'b0;
            ld_p2     = 1'b1;
          end else if (m_ready) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (m_ready) begin
            state_nxt = ST_ONE;
            rdy_nxt   = 1'b1;
            ld_p1_p2  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          rdy_nxt   = 1'b0;
        end
      endcase
    end

    // ready is low for the first cycle out of reset and rises once EMPTY is seen
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_EMPTY;
        rdy_r <= 1'b0;
      end else begin
        state <= state_nxt;
        rdy_r <= rdy_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (ld_p1_p2)     p1 <= p2;
      else if (ld_p1_s) p1 <= s_data;
      if (ld_p2)        p2 <= s_data;
    end

    assign s_ready  = rdy_r;
    assign m_valid  = state[0];
    assign m_data   = p1;
    assign occupied = (state != ST_EMPTY);

  end else if (MODE == MODE_FWD) begin : g_fwd
    logic                  vld_r;
    logic [DATA_WIDTH-1:0] dat_r;

    assign s_ready = !vld_r || m_ready;

    always_ff @(posedge clk) begin
      if (reset)                    vld_r <= 1'b0;
      else if (s_valid && s_ready)  vld_r <= 1'b1;
      else if (m_ready)             vld_r <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (s_valid && s_ready) dat_r <= s_data;
    end

    assign m_valid  = vld_r;
    assign m_data   = dat_r;
    assign occupied = vld_r;

  end else if (MODE == MODE_REV) begin : g_rev
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_dat;

    assign s_ready = !skid_vld;

    // skid catches a beat that arrives while downstream stalls
    always_ff @(posedge clk) begin
      if (reset)                     skid_vld <= 1'b0;
      else if (skid_vld)             skid_vld <= !m_ready;
      else if (s_valid && !m_ready)  skid_vld <= 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!skid_vld && s_valid && !m_ready) skid_dat <= s_data;
    end

    assign m_valid  = skid_vld || s_valid;
    assign m_data   = skid_vld ? skid_dat : s_data;
    assign occupied = skid_vld;

  end else if (MODE == MODE_BYPASS) begin : g_byp
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, reset};
    assign m_data   = s_data;
    assign m_valid  = s_valid;
    assign s_ready  = m_ready;
    assign occupied = 1'b0;

  end else begin : g_bad_mode
    $error("kernel3_gmem_A_m_axi_reg_stage: illegal MODE %0d", MODE);
  end

endmodule

// File: rtl/kernel3_gmem_a_m_axi_reg_pipe.sv
// gmem_A channel register pipeline: STAGES chained slices of one MODE.
// STAGES==0 or bypass mode degenerates to plain wires.
module kernel3_gmem_a_m_axi_reg_pipe
  import kernel3_gmem_A_m_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 1,
  parameter int MODE       = MODE_FULL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
);

  if (!mode_ok(MODE) || (STAGES < 0) || (STAGES > 8) || (DATA_WIDTH < 1)) begin : g_bad_param
    $error("kernel3_gmem_a_m_axi_reg_pipe: illegal MODE %0d / STAGES %0d / DATA_WIDTH %0d",
           MODE, STAGES, DATA_WIDTH);
  end

  if ((STAGES == 0) || (MODE == MODE_BYPASS)) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, reset};
    assign m_data  = s_data;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
    assign busy    = 1'b0;

  end else begin : g_chain
    logic [STAGES-1:0] occ;

    // per-stage nets keep the ready/valid chains as separate signals
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [DATA_WIDTH-1:0] dat_i, dat_o;
      logic                  vld_i, vld_o, rdy_i, rdy_o;

      kernel3_gmem_A_m_axi_reg_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODE       (MODE)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .s_data   (dat_i),
        .s_valid  (vld_i),
        .s_ready  (rdy_o),
        .m_data   (dat_o),
        .m_valid  (vld_o),
        .m_ready  (rdy_i),
        .occupied (occ[k])
      );

      if (k == 0) begin : g_head
        assign dat_i   = s_data;
        assign vld_i   = s_valid;
        assign s_ready = rdy_o;
      end else begin : g_link
        assign dat_i = g_stage[k-1].dat_o;
        assign vld_i = g_stage[k-1].vld_o;
      end

      if (k == STAGES - 1) begin : g_tail
        assign m_data  = dat_o;
        assign m_valid = vld_o;
        assign rdy_i   = m_ready;
      end else begin : g_back
        assign rdy_i = g_stage[k+1].rdy_o;
      end
    end

    assign busy = |occ;
  end

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_reg_pipe.sv
// Bench for the gmem_A register pipeline: several DUT configurations side by side,
// each checked against a FIFO scoreboard plus directed spot checks.
module tb_kernel3_gmem_a_m_axi_reg_pipe;
  localparam int N  = 7;
  localparam int DW = 8;
  localparam int QD = 32768;
  // idx: 0 bypass/3, 1 fwd/3, 2 rev/3, 3 full/3, 4 full/2, 5 full/1, 6 rev/1
  localparam logic [N-1:0][1:0] MD = {2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [N-1:0][3:0] ST = {4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0][DW-1:0] s_data, m_data;
  logic [N-1:0] s_valid, s_ready, m_valid, m_ready, busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    kernel3_gmem_a_m_axi_reg_pipe #(
      .DATA_WIDTH (DW),
      .STAGES     (int'(ST[g])),
      .MODE       (int'(MD[g]))
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s_data[g]),
      .s_valid (s_valid[g]),
      .s_ready (s_ready[g]),
      .m_data  (m_data[g]),
      .m_valid (m_valid[g]),
      .m_ready (m_ready[g]),
      .busy    (busy[g])
    );
  end

  // reference model: one FIFO per DUT holding accepted beats and their cycle
  logic [DW-1:0] qd [N][QD];
  int            qc [N][QD];
  int            wr [N];
  int            rd [N];
  int            nout [N];
  logic          s_xf [N];
  logic          hold [N];
  logic [DW-1:0] hold_d [N];
  int            cyc;
  int            checks;
  int            errors;
  bit            lat_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (MD[i] == 2'd1 || MD[i] == 2'd3) ? int'(ST[i]) : 0;
  endfunction

  // called mid-cycle: records handshakes that complete at the coming edge
  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      s_xf[i] = 1'b0;
      if (reset) begin
        rd[i]   = wr[i];
        hold[i] = 1'b0;
        continue;
      end
      if (hold[i]) begin
        chk($sformatf("stable_valid[%0d]", i), 32'(m_valid[i]), 32'd1);
        chk($sformatf("stable_data[%0d]", i), 32'(m_data[i]), 32'(hold_d[i]));
      end
      if (s_valid[i] && s_ready[i]) begin
        qd[i][wr[i] % QD] = s_data[i];
        qc[i][wr[i] % QD] = cyc;
        wr[i]++;
        s_xf[i] = 1'b1;
      end
      if (m_valid[i] && m_ready[i]) begin
        chk($sformatf("beat_expected[%0d]", i), 32'(rd[i] < wr[i]), 32'd1);
        if (rd[i] < wr[i]) begin
          chk($sformatf("order[%0d]", i), 32'(m_data[i]), 32'(qd[i][rd[i] % QD]));
          if (lat_chk)
            chk($sformatf("latency[%0d]", i), 32'(cyc - qc[i][rd[i] % QD]), 32'(lat_of(i)));
          rd[i]++;
          nout[i]++;
        end
      end
      hold[i]   = m_valid[i] && !m_ready[i];
      hold_d[i] = m_data[i];
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [DW-1:0] items [3];
  initial begin
    int k;
    int base;
    int guard;
    int nb [4];
    bit done;
    items = '{8'h11, 8'h22, 8'h33};
    checks = 0; errors = 0; cyc = 0; lat_chk = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0; rd[i] = 0; nout[i] = 0; hold[i] = 1'b0; s_xf[i] = 1'b0; hold_d[i] = '0;
    end
    s_valid = '0; m_ready = '0; s_data = '0;
    reset = 1'b1;

    // reset and the full-mode ready ramp (full, 2 stages)
    s_valid[4] = 1'b1; s_data[4] = 8'h40; m_ready[4] = 1'b1;
    repeat (3) begin
      sample();
      chk("rst_s_ready_full", 32'(s_ready[4]), 32'd0);
      adv();
    end
    sample();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_m_valid[%0d]", i), 32'(m_valid[i]), 32'd0);
      chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
    end
    adv();
    reset = 1'b0;
    sample();
    chk("post_rst_s_ready_full", 32'(s_ready[4]), 32'd0);
    chk("post_rst_s_ready_fwd", 32'(s_ready[1]), 32'd1);
    chk("post_rst_s_ready_rev", 32'(s_ready[2]), 32'd1);
    adv();
    sample();
    chk("second_s_ready_full", 32'(s_ready[4]), 32'd1);
    adv();
    s_valid[4] = 1'b0;
    sample();
    chk("lat2_m_valid_c1", 32'(m_valid[4]), 32'd0);
    adv();
    sample();
    chk("lat2_m_valid_c2", 32'(m_valid[4]), 32'd1);
    chk("lat2_m_data", 32'(m_data[4]), 32'h40);
    adv();
    m_ready[4] = 1'b0;
    repeat (3) begin sample(); adv(); end

    // full-rate stream 0x00..0xFF through each mode with 3 stages
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin m_ready[i] = 1'b1; nb[i] = nout[i]; end
    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < 4; i++) begin s_valid[i] = 1'b1; s_data[i] = 8'(v); end
      sample();
      for (int i = 0; i < 4; i++) chk($sformatf("stream_s_ready[%0d]", i), 32'(s_ready[i]), 32'd1);
      adv();
    end
    for (int i = 0; i < 4; i++) s_valid[i] = 1'b0;
    repeat (6) begin sample(); adv(); end
    for (int i = 0; i < 4; i++) chk($sformatf("stream_count[%0d]", i), 32'(nout[i] - nb[i]), 32'd256);
    lat_chk = 1'b0;
    for (int i = 0; i < 4; i++) m_ready[i] = 1'b0;

    // full mode, 1 stage: capacity two, then ordered release
    k = 0; base = wr[5];
    s_valid[5] = 1'b1; s_data[5] = items[0]; m_ready[5] = 1'b0;
    repeat (8) begin
      sample(); adv();
      if (s_xf[5]) begin
        k++;
        if (k < 3) s_data[5] = items[k]; else s_valid[5] = 1'b0;
      end
    end
    sample();
    chk("cap_accepted", 32'(wr[5] - base), 32'd2);
    chk("cap_s_ready", 32'(s_ready[5]), 32'd0);
    chk("cap_busy", 32'(busy[5]), 32'd1);
    chk("cap_head", 32'(m_data[5]), 32'h11);
    adv();
    m_ready[5] = 1'b1;
    sample();
    chk("rel_first", 32'(m_data[5]), 32'h11);
    chk("rel_first_s_ready", 32'(s_ready[5]), 32'd0);
    adv();
    sample();
    chk("rel_second", 32'(m_data[5]), 32'h22);
    chk("rel_second_s_ready", 32'(s_ready[5]), 32'd1);
    adv();
    if (s_xf[5]) s_valid[5] = 1'b0;
    sample();
    chk("rel_third", 32'(m_data[5]), 32'h33);
    chk("rel_third_valid", 32'(m_valid[5]), 32'd1);
    adv();
    s_valid[5] = 1'b0;
    sample();
    chk("rel_empty_valid", 32'(m_valid[5]), 32'd0);
    chk("rel_empty_busy", 32'(busy[5]), 32'd0);
    adv();

    // reverse mode, 1 stage: same-cycle pass-through then skid hold
    m_ready[6] = 1'b0; s_valid[6] = 1'b1; s_data[6] = 8'hA5;
    sample();
    chk("rev_pass_data", 32'(m_data[6]), 32'hA5);
    chk("rev_pass_valid", 32'(m_valid[6]), 32'd1);
    chk("rev_pass_s_ready", 32'(s_ready[6]), 32'd1);
    adv();
    s_valid[6] = 1'b0; s_data[6] = 8'h00;
    sample();
    chk("rev_skid_s_ready", 32'(s_ready[6]), 32'd0);
    chk("rev_skid_data", 32'(m_data[6]), 32'hA5);
    chk("rev_skid_busy", 32'(busy[6]), 32'd1);
    adv();
    m_ready[6] = 1'b1;
    sample();
    chk("rev_release_data", 32'(m_data[6]), 32'hA5);
    adv();
    sample();
    chk("rev_after_s_ready", 32'(s_ready[6]), 32'd1);
    chk("rev_after_valid", 32'(m_valid[6]), 32'd0);
    chk("rev_after_busy", 32'(busy[6]), 32'd0);
    adv();
    m_ready[6] = 1'b0;

    // random valid/ready in every mode; sources hold valid/data until accepted
    for (int i = 0; i < 4; i++) nb[i] = nout[i];
    guard = 0; done = 1'b0;
    while (!done && guard < 60000) begin
      sample(); adv();
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (!s_valid[i] || s_xf[i]) begin
          s_valid[i] = 1'($urandom_range(0, 1));
          s_data[i]  = 8'($urandom);
        end
        m_ready[i] = 1'($urandom_range(0, 1));
        if (nout[i] - nb[i] < 10000) done = 1'b0;
      end
      guard++;
    end
    chk("rand_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) m_ready[i] = 1'b1;
    repeat (20) begin
      sample(); adv();
      for (int i = 0; i < 4; i++) if (s_xf[i]) s_valid[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand_drained[%0d]", i), 32'(wr[i] - rd[i]), 32'd0);
      chk($sformatf("rand_busy[%0d]", i), 32'(busy[i]), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin s_valid[i] = 1'b0; m_ready[i] = 1'b0; end

    // full mode, 2 stages: fill to capacity, then reset discards everything
    m_ready[4] = 1'b0; s_valid[4] = 1'b1; s_data[4] = 8'($urandom);
    repeat (12) begin
      sample(); adv();
      if (s_xf[4]) s_data[4] = 8'($urandom);
    end
    sample();
    chk("fill_held", 32'(wr[4] - rd[4]), 32'd4);
    chk("fill_s_ready", 32'(s_ready[4]), 32'd0);
    chk("fill_busy", 32'(busy[4]), 32'd1);
    adv();
    reset = 1'b1; s_valid[4] = 1'b0;
    sample();
    adv();
    reset = 1'b0; m_ready[4] = 1'b1;
    sample();
    chk("mid_rst_m_valid", 32'(m_valid[4]), 32'd0);
    chk("mid_rst_busy", 32'(busy[4]), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready[4]), 32'd0);
    adv();
    repeat (6) begin
      sample();
      chk("no_stale_valid", 32'(m_valid[4]), 32'd0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel3_gmem_a_m_axi_reg_pipe.md
# kernel3_gmem_A_m_axi_reg_pipe

Parametrised valid/ready register pipeline for the gmem_A AXI master channels (AW, W, AR, R, B). It chains `STAGES` identical slices and selects one of four slice modes: full two-entry skid, forward-registered, reverse-registered or bypass. Timing closure can then be tuned per channel without changing the interface. It sits between the m_axi core logic and the AXI port, on the same clock.

## Interface
- `DATA_WIDTH`, 8: payload width in bits, ≥1.
- `STAGES`, 1: number of chained slices, 0..8; 0 means wire-through regardless of `MODE`.
- `MODE`, 3: 0 = bypass, 1 = forward (data/valid registered), 2 = reverse (ready registered), 3 = full (data, valid and ready all registered).
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  DATA_WIDTH  upstream payload.
- `s_valid`  in  1  upstream valid.
- `s_ready`  out  DATA_WIDTH-independent 1  upstream ready.
- `m_data`  out  DATA_WIDTH  downstream payload.
- `m_valid`  out  1  downstream valid.
- `m_ready`  in  1  downstream ready.
- `busy`  out  1  OR of all stage occupancy flags; high while any beat is held internally.

## Operation
- Handshakes:
  - A beat transfers on a port when valid and ready are both high at a rising edge.
  - Order is strictly preserved; no beat is dropped or duplicated.
  - Once asserted, `m_valid` and `m_data` stay stable until `m_ready` is seen.
- Stage k's master side drives stage k+1's slave side.
- Full mode (3), per-stage FSM with states EMPTY, ONE and TWO (two data registers p1/p2; `m_data`=p1):
  - EMPTY→ONE on s_valid&s_ready.
  - ONE→EMPTY on ~s_valid&m_ready.
  - ONE→TWO on s_valid&~m_ready.
  - TWO→ONE on m_ready.
  - Otherwise the state holds.
  - `m_valid`=(state≠EMPTY). `s_ready` is a register: set in EMPTY, cleared on ONE→TWO, set on TWO→ONE.
  - On TWO→ONE, p1 loads from p2; otherwise p1 loads from `s_data`.
- Forward mode (1):
  - One register per stage, with a valid bit.
  - `s_ready` = ~valid | m_ready (combinational); the register loads on s_valid&s_ready.
- Reverse mode (2):
  - One skid register per stage. `s_ready` = ~skid_valid (registered).
  - While the skid register is empty, `m_data`/`m_valid` pass through combinationally.
  - The skid register loads on s_valid&s_ready&~m_ready. While it is full, it drives `m_data`/`m_valid`, and it empties on m_ready.
- Bypass (0) or `STAGES`=0: `m_data`=`s_data`, `m_valid`=`s_valid`, `s_ready`=`m_ready`, `busy`=0.
- Illegal `MODE` values are rejected at elaboration.

## Timing
- Reset values:
  - All stages empty; `m_valid`=0 and `busy`=0.
  - Full mode: `s_ready`=0 during reset and in the first cycle after reset deasserts, then 1.
  - Forward mode: `s_ready`=1 once out of reset.
  - Reverse mode: `s_ready`=1 out of reset.
  - Data registers are not reset.
- Latency from s-transfer to `m_valid`:
  - full: `STAGES` cycles
  - forward: `STAGES` cycles
  - reverse: 0 cycles
  - bypass: 0 cycles
- Throughput is one beat per cycle in every mode when `m_ready` is held high.
- Capacity is 2×`STAGES` beats (full), `STAGES` (forward) or `STAGES` (reverse). When capacity is reached, `s_ready` drops no later than the cycle after the filling transfer.
- Simultaneous input and output transfer in ONE keeps the state at ONE, with p1 taking the new beat.
- Reset mid-operation discards all held beats, and outputs take their reset values at the next edge.
- Combinational paths:
  - full mode: none between s and m sides.
  - forward mode: m_ready→s_ready only.
  - reverse mode: s→m data/valid only.

## Structure
- Shared package `kernel3_gmem_A_m_axi_pkg` holds:
  - the mode constants (MODE_BYPASS, MODE_FWD, MODE_REV, MODE_FULL);
  - the full-mode state encodings (EMPTY=2'b10, ONE=2'b11, TWO=2'b01), so bit 0 is `m_valid`.
- One sub-module, `kernel3_gmem_A_m_axi_reg_stage` (params `DATA_WIDTH`, `MODE`), is instantiated `STAGES` times in a generate loop. It exports an `occupied` flag for `busy`.

## Test plan
- Reset, `MODE`=3, `STAGES`=2, `s_valid`=1 constant → `s_ready`=0 in the first cycle after reset, 1 from the second; first `m_valid` two cycles after the first s-transfer.
- `MODE`=3, `STAGES`=1, `m_ready`=0, push 0x11, 0x22, 0x33 → only 0x11 and 0x22 accepted, `s_ready`=0, `busy`=1. Then `m_ready`=1 → 0x11 then 0x22 out on consecutive cycles, then 0x33 accepted.
- Each mode with `STAGES`=3 and `m_ready`=1, stream 0x00..0xFF → all 256 beats in order, one per cycle after fill, with per-mode latency matching the Timing section.
- Random `s_valid`/`m_ready` (50%) for 10k beats in every mode → scoreboard shows no loss, duplication or reordering, and `m_data` is stable while `m_valid`&~`m_ready`.
- `MODE`=2, `m_ready`=0, push 0xA5 → 0xA5 appears on `m_data` in the same cycle, the skid register holds it, `s_ready`=0 next cycle; `m_ready`=1 → released, `s_ready`=1.
- Assert `reset` with 4 beats held (`MODE`=3, `STAGES`=2) → next cycle `m_valid`=0 and `busy`=0; no stale beat emerges afterwards.
